// File: rtl/gvizi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gvizi_pkg
//  Description : Shared types and constants for the channel start sequencer:
//                FSM state encoding, miss-counter width, mode encodings and a
//                constant helper for sizing the shared timer.
//  Revision    : 1.0  initial release
// ============================================================================
package gvizi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHARGE = 2'd1,
        ARM    = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int MISS_W = 8;

    localparam logic MOD_GZI = 1'b0;
    localparam logic MOD_GVI = 1'b1;

    // Largest of three integers, used to size the shared down-counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Three-flop synchronizer for an asynchronous level with a
//                registered single-cycle rising-edge pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_rise;

    // Metastability chain; the rise pulse is taken from the two settled stages.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_rise <= r_s2 & ~r_s3;
        end
    end

    assign o_rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/ch_start_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ch_start_sequencer
//  Description : Holds per-channel delay words/enables in a shadow bank with
//                atomic commit, turns an async trigger into the first-charge
//                pulse and start level for the delay counters, aborts shots
//                that never complete and counts triggers lost while busy.
//  Revision    : 1.0  initial release
// ============================================================================
module ch_start_sequencer
    import gvizi_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DW      = 16,
    parameter int FC_LEN  = 4,
    parameter int TMO_LEN = 65535,
    parameter int HOLDOFF = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_trig,
    input  logic                    i_wr,
    input  logic [$clog2(N_CH)-1:0] i_waddr,
    input  logic [DW-1:0]           i_wdata,
    input  logic                    i_wen,
    input  logic                    i_mod_wr,
    input  logic                    i_commit,
    input  logic [N_CH-1:0]         i_ch_done,
    output logic [N_CH*DW-1:0]      o_data,
    output logic [N_CH-1:0]         o_ch_enable,
    output logic                    o_mod,
    output logic                    o_first_charge,
    output logic                    o_start,
    output logic                    o_busy,
    output logic                    o_timeout,
    output logic [MISS_W-1:0]       o_miss_cnt
);

    localparam int c_aw      = $clog2(N_CH);
    localparam int c_tmr_max = max3(FC_LEN, TMO_LEN, HOLDOFF);
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

    // Timer load values are "cycles - 1" because the zero cycle is counted too.
    localparam logic [c_tmr_w-1:0] c_fc_load  = c_tmr_w'(FC_LEN - 1);
    localparam logic [c_tmr_w-1:0] c_tmo_load = c_tmr_w'(TMO_LEN - 1);
    localparam logic [c_tmr_w-1:0] c_ho_load  = c_tmr_w'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_one  = c_tmr_w'(1);

    // Shadow and active banks
    logic [DW-1:0]     r_sh_data  [N_CH];
    logic [N_CH-1:0]   r_sh_en;
    logic [DW-1:0]     r_act_data [N_CH];
    logic [N_CH-1:0]   r_act_en;
    logic              r_mod_sh;
    logic              r_mod;
    logic              r_pend;

    // Sequencer state
    state_t            r_state;
    logic [c_tmr_w-1:0] r_tmr;
    logic              r_fc;
    logic              r_start;
    logic              r_timeout;
    logic [N_CH-1:0]   r_done_seen;
    logic [MISS_W-1:0] r_miss;

    // Done synchronizers
    logic [N_CH-1:0]   r_done_s1;
    logic [N_CH-1:0]   r_done_s2;

    logic              w_trig_rise;
    logic              w_apply;
    logic [N_CH-1:0]   w_en_eff;
    logic              w_trig_go;
    logic              w_done_all;

    sync_edge u_trig_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_trig),
        .o_rise  (w_trig_rise)
    );

    // A pending commit is applied only while idle, so a running shot never
    // sees its configuration change. The trigger check in that same cycle
    // uses the enables being committed.
    assign w_apply    = r_pend && (r_state == IDLE);
    assign w_en_eff   = w_apply ? r_sh_en : r_act_en;
    assign w_trig_go  = w_trig_rise && (w_en_eff != '0);
    assign w_done_all = (((r_done_seen | r_done_s2) & r_act_en) == r_act_en);

    // Shadow bank writes; out-of-range addresses match no channel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < N_CH; c++) begin
                r_sh_data[c] <= '0;
            end
            r_sh_en <= '0;
        end else if (i_wr) begin
            for (int c = 0; c < N_CH; c++) begin
                if (i_waddr == c_aw'(c)) begin
                    r_sh_data[c] <= i_wdata;
                    r_sh_en[c]   <= i_wen;
                end
            end
        end
    end

    // Commit request tracking; a new request wins over clearing on apply.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend   <= 1'b0;
            r_mod_sh <= MOD_GZI;
        end else if (i_commit) begin
            r_pend   <= 1'b1;
            r_mod_sh <= i_mod_wr ? MOD_GVI : MOD_GZI;
        end else if (w_apply) begin
            r_pend   <= 1'b0;
        end
    end

    // Active bank copy from shadow on an idle cycle with a pending commit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < N_CH; c++) begin
                r_act_data[c] <= '0;
            end
            r_act_en <= '0;
            r_mod    <= MOD_GZI;
        end else if (w_apply) begin
            for (int c = 0; c < N_CH; c++) begin
                r_act_data[c] <= r_sh_data[c];
            end
            r_act_en <= r_sh_en;
            r_mod    <= r_mod_sh;
        end
    end

    // Two-flop synchronizer per channel-done bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done_s1 <= '0;
            r_done_s2 <= '0;
        end else begin
            r_done_s1 <= i_ch_done;
            r_done_s2 <= r_done_s1;
        end
    end

    // Saturating count of trigger edges arriving while a shot is in progress.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_miss <= '0;
        end else if (w_trig_rise && (r_state != IDLE) && (r_miss != '1)) begin
            r_miss <= r_miss + MISS_W'(1);
        end
    end

    // Shot sequencer with registered outputs and one shared down-counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_tmr       <= '0;
            r_fc        <= 1'b0;
            r_start     <= 1'b0;
            r_timeout   <= 1'b0;
            r_done_seen <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_fc    <= 1'b0;
                    r_start <= 1'b0;
                    if (w_trig_go) begin
                        r_state <= CHARGE;
                        r_fc    <= 1'b1;
                        r_tmr   <= c_fc_load;
                    end
                end
                CHARGE: begin
                    if (r_tmr == '0) begin
                        r_state <= ARM;
                        r_fc    <= 1'b0;
                        r_start <= 1'b1;
                        r_tmr   <= c_tmo_load;
                    end else begin
                        r_tmr <= r_tmr - c_tmr_one;
                    end
                end
                ARM: begin
                    r_done_seen <= r_done_seen | r_done_s2;
                    // Completion takes priority over a coincident timeout.
                    if (w_done_all) begin
                        r_state <= HOLD;
                        r_start <= 1'b0;
                        r_tmr   <= c_ho_load;
                    end else if (r_tmr == '0) begin
                        r_state   <= HOLD;
                        r_start   <= 1'b0;
                        r_timeout <= 1'b1;
                        r_tmr     <= c_ho_load;
                    end else begin
                        r_tmr <= r_tmr - c_tmr_one;
                    end
                end
                HOLD: begin
                    if (r_tmr == '0) begin
                        r_state     <= IDLE;
                        r_done_seen <= '0;
                    end else begin
                        r_tmr <= r_tmr - c_tmr_one;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_out
            assign o_data[g*DW +: DW] = r_act_data[g];
        end
    endgenerate

    assign o_ch_enable    = r_act_en;
    assign o_mod          = r_mod;
    assign o_first_charge = r_fc;
    assign o_start        = r_start;
    assign o_busy         = (r_state != IDLE);
    assign o_timeout      = r_timeout;
    assign o_miss_cnt     = r_miss;

endmodule

`default_nettype wire
